sn74138_scan_driver: RTL and testbench

//  Sequencer that drives an SN74138 3-to-8 decoder: produces the enable vector
//  {G1,G2a_n,G2b_n} and select code {C,B,A}, stepping codes 0..LAST_CODE.

---
 rtl/sn74138_scan_driver.sv | 138 +++++++++++++
 tb/tb_sn74138_scan_driver.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sn74138_scan_driver.sv
// Scan sequencer for an SN74138 decoder: steps select codes 0..LAST_CODE with a blanking gap so
// the select never moves while the decoder is enabled. Optional SCAN_HOLD_EN adds a 'hold' input.
module sn74138_scan_driver #(
  parameter int DWELL     = 50,
  parameter int BLANK     = 2,
  parameter int LAST_CODE = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       loop_en,
  output logic [2:0] dec_en,
  output logic [2:0] dec_in,
  output logic       code_vld,
  output logic       busy,
  output logic       done
`ifdef SCAN_HOLD_EN
  ,
  input  logic       hold
`endif
);

  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0]       EN_ON      = 3'b100;
  localparam logic [2:0]       EN_OFF     = 3'b011;
  localparam logic [2:0]       LAST_SEL   = 3'(LAST_CODE);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK > 0) ? CNT_W'(BLANK - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_DWELL,
    ST_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             frozen;

`ifdef SCAN_HOLD_EN
  assign frozen = hold && ((state == ST_BLANK) || (state == ST_DWELL));
`else
  assign frozen = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      dec_en   <= EN_OFF;
      dec_in   <= 3'b000;
      code_vld <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (abort) begin
      // dec_in deliberately keeps the last code on abort
      state    <= ST_IDLE;
      cnt      <= '0;
      dec_en   <= EN_OFF;
      code_vld <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (!frozen) begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            cnt    <= '0;
            dec_in <= 3'b000;
            busy   <= 1'b1;
            if (BLANK > 0) begin
              state <= ST_BLANK;
            end else begin
              state    <= ST_DWELL;
              dec_en   <= EN_ON;
              code_vld <= 1'b1;
            end
          end
        end

        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt      <= '0;
            state    <= ST_DWELL;
            dec_en   <= EN_ON;
            code_vld <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DWELL: begin
          if (cnt == DWELL_LAST) begin
            cnt <= '0;
            if ((dec_in < LAST_SEL) || loop_en) begin
              // select only moves on this edge, as the decoder turns off (or between dwells when BLANK==0)
              dec_in <= (dec_in < LAST_SEL) ? dec_in + 3'd1 : 3'd0;
              if (BLANK > 0) begin
                state    <= ST_BLANK;
                dec_en   <= EN_OFF;
                code_vld <= 1'b0;
              end else begin
                state <= ST_DWELL;
              end
            end else begin
              state    <= ST_DONE;
              dec_en   <= EN_OFF;
              code_vld <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state    <= ST_IDLE;
          cnt      <= '0;
          dec_en   <= EN_OFF;
          code_vld <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sn74138_scan_driver.sv
// Bench for sn74138_scan_driver: expected per-cycle outputs are queued from the scan timeline
// and popped one per clock. Define SCAN_HOLD_EN to also exercise the hold input.
module tb_sn74138_scan_driver;

  localparam int DWELL     = 4;
  localparam int BLANK     = 2;
  localparam int LAST_CODE = 7;

  typedef struct packed {
    logic [2:0] en;
    logic [2:0] sel;
    logic       vld;
    logic       busy;
    logic       done;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, abort = 1'b0, loop_en = 1'b0, hold = 1'b0;
  logic start0 = 1'b0, abort0 = 1'b0, loop0 = 1'b0, hold0 = 1'b0;

  logic [2:0] dec_en, dec_in, dec_en0, dec_in0;
  logic       code_vld, busy, done, code_vld0, busy0, done0;

  obs_t exp_q[$];
  obs_t exp0_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sn74138_scan_driver #(.DWELL(DWELL), .BLANK(BLANK), .LAST_CODE(LAST_CODE)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .loop_en(loop_en),
    .dec_en(dec_en), .dec_in(dec_in), .code_vld(code_vld), .busy(busy), .done(done)
`ifdef SCAN_HOLD_EN
    , .hold(hold)
`endif
  );

  sn74138_scan_driver #(.DWELL(DWELL), .BLANK(0), .LAST_CODE(LAST_CODE)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .abort(abort0), .loop_en(loop0),
    .dec_en(dec_en0), .dec_in(dec_in0), .code_vld(code_vld0), .busy(busy0), .done(done0)
`ifdef SCAN_HOLD_EN
    , .hold(hold0)
`endif
  );

  function automatic obs_t mk(input logic [2:0] en, input logic [2:0] sel,
                              input logic vld, input logic bsy, input logic dn);
    obs_t r;
    r.en = en; r.sel = sel; r.vld = vld; r.busy = bsy; r.done = dn;
    return r;
  endfunction

  function automatic obs_t obs();
    return {dec_en, dec_in, code_vld, busy, done};
  endfunction

  function automatic obs_t obs0();
    return {dec_en0, dec_in0, code_vld0, busy0, done0};
  endfunction

  function void push(input bit to0, input obs_t e);
    if (to0) exp0_q.push_back(e);
    else     exp_q.push_back(e);
  endfunction

  // One code slot: blank cycles with the decoder off, then dwell cycles with it on.
  function void push_code(input bit to0, input int c, input int blank, input int dwell);
    for (int b = 0; b < blank; b++) push(to0, mk(3'b011, 3'(c), 1'b0, 1'b1, 1'b0));
    for (int d = 0; d < dwell; d++) push(to0, mk(3'b100, 3'(c), 1'b1, 1'b1, 1'b0));
  endfunction

  function void push_pass(input bit to0, input int blank, input int extra2);
    for (int c = 0; c <= LAST_CODE; c++)
      push_code(to0, c, blank, DWELL + ((c == 2) ? extra2 : 0));
  endfunction

  function void push_done(input bit to0, input int c);
    push(to0, mk(3'b011, 3'(c), 1'b0, 1'b0, 1'b1));
  endfunction

  function void push_idle(input bit to0, input int c, input int n);
    for (int i = 0; i < n; i++) push(to0, mk(3'b011, 3'(c), 1'b0, 1'b0, 1'b0));
  endfunction

  task automatic test_reset;
    obs_t o, e;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    e = mk(3'b011, 3'b000, 1'b0, 1'b0, 1'b0);
    o = obs();
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL reset_por: got %b required %b", o, e);
    end
    o = obs0();
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL reset_por_blank0: got %b required %b", o, e);
    end
    reset = 1'b0;
    // run into the second dwell cycle of code 3, then reset for 3 cycles
    push_pass(1'b0, BLANK, 0);
    start = 1'b1;
    for (int i = 0; i < 22; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      o = obs();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_prerun cycle %0d: got %b required %b", i, o, e);
      end
    end
    exp_q.delete();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      o = obs();
      e = mk(3'b011, 3'b000, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_mid_dwell cycle %0d: got %b required %b", i, o, e);
      end
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    o = obs();
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL reset_release: got %b required %b", o, e);
    end
  endtask

  task automatic test_pass;
    obs_t o, e;
    obs_t prev;
    int   n;
    push_pass(1'b0, BLANK, 0);
    push_done(1'b0, LAST_CODE);
    push_idle(1'b0, LAST_CODE, 2);
    n = exp_q.size();
    prev = obs();
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      start = (i == 10);  // start mid-pass must be ignored
      o = obs();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL pass cycle %0d: got %b required %b", i, o, e);
      end
      if (prev.vld && o.vld) begin
        n_checks++;
        if (o.sel !== prev.sel) begin
          n_fail++;
          $display("FAIL sel_stable_while_enabled cycle %0d: got %0d required %0d", i, o.sel, prev.sel);
        end
      end
      prev = o;
    end
  endtask

  task automatic test_blank0;
    obs_t o, e;
    int   n, run;
    push_pass(1'b1, 0, 0);
    push_done(1'b1, LAST_CODE);
    push_idle(1'b1, LAST_CODE, 2);
    n = exp0_q.size();
    run = 0;
    start0 = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      start0 = 1'b0;
      o = obs0();
      if (o.vld) run++;
      e = exp0_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL blank0 cycle %0d: got %b required %b", i, o, e);
      end
    end
    n_checks++;
    if (run !== (LAST_CODE + 1) * DWELL) begin
      n_fail++;
      $display("FAIL blank0_enabled_run: got %0d required %0d", run, (LAST_CODE + 1) * DWELL);
    end
  endtask

  task automatic test_loop;
    obs_t o, e;
    int   n;
    push_pass(1'b0, BLANK, 0);
    push_pass(1'b0, BLANK, 0);
    push_done(1'b0, LAST_CODE);
    push_idle(1'b0, LAST_CODE, 2);
    n = exp_q.size();
    loop_en = 1'b1;
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      loop_en = (i < 60);  // dropped partway through the second pass
      o = obs();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL loop cycle %0d: got %b required %b", i, o, e);
      end
    end
    loop_en = 1'b0;
  endtask

  task automatic test_abort;
    obs_t o, e;
    int   n;
    for (int c = 0; c < 5; c++) push_code(1'b0, c, BLANK, DWELL);
    push_code(1'b0, 5, BLANK, 2);
    push_idle(1'b0, 5, 3);
    n = exp_q.size();
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = (i == 33);
      o = obs();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL abort cycle %0d: got %b required %b", i, o, e);
      end
    end
    abort = 1'b0;
    push_idle(1'b0, 5, 3);
    start = 1'b1;
    abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      o = obs();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL start_abort_idle cycle %0d: got %b required %b", i, o, e);
      end
    end
  endtask

`ifdef SCAN_HOLD_EN
  task automatic test_hold;
    obs_t o, e;
    int   n;
    push_pass(1'b0, BLANK, 10);
    push_done(1'b0, LAST_CODE);
    push_idle(1'b0, LAST_CODE, 2);
    n = exp_q.size();
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      hold = (i >= 15) && (i < 25);
      o = obs();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL hold cycle %0d: got %b required %b", i, o, e);
      end
    end
    hold = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_pass();
    test_blank0();
    test_loop();
    test_abort();
`ifdef SCAN_HOLD_EN
    test_hold();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
